expr_result_sig: RTL and testbench

//   Downstream capture stage for the vloghammer expression blocks. Consumes the packed 90-bit

---
 rtl/expr_result_sig.sv | 115 +++++++++++
 tb/tb_expr_result_sig.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/expr_result_sig.sv
// Result capture stage: absorbs NUM result words into a MISR signature over a
// valid/ready handshake, then reports the signature and a compare against golden.
module expr_result_sig #(
    parameter int          DW   = 90,
    parameter int          SW   = 32,
    parameter int          CW   = 16,
    parameter logic [SW-1:0] POLY = 32'h04C11DB7,
    parameter logic [SW-1:0] SEED = 32'hFFFFFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] num_vec,
    input  logic [SW-1:0] golden,
    input  logic          y_valid,
    input  logic [DW-1:0] y_data,
    output logic          y_ready,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [SW-1:0] signature,
    output logic [CW-1:0] vec_count
);

    localparam int NSL = (DW + SW - 1) / SW;
    localparam int PW  = NSL * SW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_sig;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_target;

    state_t        w_nstate;
    logic [SW-1:0] w_sig_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_tgt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic [PW-1:0] w_pad;
    logic [SW-1:0] w_fold;
    logic [SW-1:0] w_misr;
    logic          w_accept;

    // Zero-pad the result word to whole SW slices and XOR the slices together.
    always_comb begin
        w_pad          = '0;
        w_pad[DW-1:0]  = y_data;
        w_fold         = '0;
        for (int k = 0; k < NSL; k++) begin
            w_fold = w_fold ^ w_pad[k*SW +: SW];
        end
    end

    assign w_misr    = {r_sig[SW-2:0], 1'b0} ^ (r_sig[SW-1] ? POLY : '0) ^ w_fold;
    assign w_accept  = y_valid && (r_state == S_RUN);
    assign w_cnt_inc = r_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sig    <= SEED;
            r_cnt    <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_nstate;
            r_sig    <= w_sig_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_tgt_nxt;
        end
    end

    always_comb begin
        w_nstate  = r_state;
        w_sig_nxt = r_sig;
        w_cnt_nxt = r_cnt;
        w_tgt_nxt = r_target;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_sig_nxt = SEED;
                    w_cnt_nxt = '0;
                    w_tgt_nxt = num_vec;
                    w_nstate  = (num_vec == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // start is deliberately not looked at here: a run cannot be restarted.
                if (w_accept) begin
                    w_sig_nxt = w_misr;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_target) begin
                        w_nstate = S_DONE;
                    end
                end
            end
            default: begin
                w_nstate = S_IDLE;
            end
        endcase
    end

    // All handshake/status outputs decode registered state only.
    assign y_ready   = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign pass      = done && (r_sig == golden);
    assign signature = r_sig;
    assign vec_count = r_cnt;

endmodule

// File: tb/tb_expr_result_sig.sv
// Directed bench for expr_result_sig: single-word vector table plus hand-written
// multi-cycle sequences (gaps, mid-run start, reset abort, back-to-back runs).
module tb_expr_result_sig;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_vec;
    logic [31:0] golden;
    logic        y_valid;
    logic [89:0] y_data;
    logic        y_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;
    logic [15:0] vec_count;

    int total = 0;
    int bad   = 0;

    expr_result_sig dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_vec   (num_vec),
        .golden    (golden),
        .y_valid   (y_valid),
        .y_data    (y_data),
        .y_ready   (y_ready),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [89:0] y;
        logic [31:0] exp_sig;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [89:0] y);
        logic [31:0] f;
        f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    function automatic logic [89:0] rnd90();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[89:0];
    endfunction

    task automatic do_start(input logic [15:0] n);
        start   = 1'b1;
        num_vec = n;
        tick();
        start   = 1'b0;
    endtask

    // One word offered for one cycle; model advances only if the DUT was ready.
    task automatic push(input logic [89:0] d, inout logic [31:0] model, inout int acc);
        y_valid = 1'b1;
        y_data  = d;
        if (y_ready) begin
            model = misr(model, d);
            acc++;
        end
        tick();
        y_valid = 1'b0;
    endtask

    vec_t vtab[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] model;
        logic [31:0] held;
        int          acc;
        int          cyc;

        // From SEED: shift gives FFFFFFFE, msb set -> ^POLY = FB3EE249, then ^fold.
        vtab[0] = '{90'h0,                                            32'hFB3EE249};
        vtab[1] = '{90'h1,                                            32'hFB3EE248};
        vtab[2] = '{{26'h0, 32'h0, 32'hFFFFFFFF},                     32'h04C11DB6};
        vtab[3] = '{{26'h3FFFFFF, 32'h0, 32'h0},                      32'hF8C11DB6};
        vtab[4] = '{{26'h1, 32'hA5A5A5A5, 32'h5A5A5A5B},              32'h04C11DB6};

        reset = 1'b1; start = 1'b0; num_vec = '0; golden = SEED;
        y_valid = 1'b0; y_data = '0;
        tick(); tick();
        chk("rst_sig",   signature, SEED);
        chk("rst_cnt",   vec_count, 0);
        chk("rst_ready", y_ready, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_pass",  pass, 0);
        reset = 1'b0;
        tick();

        // Single-word runs
        for (int i = 0; i < 5; i++) begin
            model = SEED; acc = 0;
            do_start(16'd1);
            chk($sformatf("t%0d_busy", i), busy, 1);
            push(vtab[i].y, model, acc);
            chk($sformatf("t%0d_sig", i), signature, vtab[i].exp_sig);
            chk($sformatf("t%0d_done", i), done, 1);
            chk($sformatf("t%0d_cnt", i), vec_count, 1);
            golden = vtab[i].exp_sig; #1;
            chk($sformatf("t%0d_pass1", i), pass, 1);
            golden = 32'h0; #1;
            chk($sformatf("t%0d_pass0", i), pass, 0);
        end

        // num_vec = 0: straight to DONE, never ready
        y_valid = 1'b1; y_data = 90'h123;
        do_start(16'd0);
        chk("z_done", done, 1);
        chk("z_sig",  signature, SEED);
        chk("z_cnt",  vec_count, 0);
        for (int i = 0; i < 3; i++) begin
            chk("z_ready", y_ready, 0);
            tick();
        end
        chk("z_sig_hold", signature, SEED);
        y_valid = 1'b0;

        // num_vec = 4 with valid toggling
        model = SEED; acc = 0; cyc = 0;
        do_start(16'd4);
        while (!done && cyc < 40) begin
            if (cyc % 2 == 0) push(rnd90(), model, acc);
            else tick();
            cyc++;
        end
        chk("g_done",  done, 1);
        chk("g_acc",   acc, 4);
        chk("g_cnt",   vec_count, 4);
        chk("g_sig",   signature, model);
        held = signature;
        for (int i = 0; i < 5; i++) push(rnd90(), model, acc);
        chk("g_extra_acc", acc, 4);
        chk("g_extra_cnt", vec_count, 4);
        chk("g_extra_sig", signature, held);

        // start pulsed mid-run after 2 of 5
        model = SEED; acc = 0;
        do_start(16'd5);
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) begin
                start = 1'b1; num_vec = 16'd9;
            end
            push(rnd90(), model, acc);
            start = 1'b0;
            chk($sformatf("m_cnt%0d", i), vec_count, i);
            chk($sformatf("m_sig%0d", i), signature, model);
        end
        chk("m_done", done, 1);
        tick();
        chk("m_ready", y_ready, 0);

        // reset after 3 of 8
        model = SEED; acc = 0;
        do_start(16'd8);
        for (int i = 0; i < 3; i++) push(rnd90(), model, acc);
        chk("r_cnt3", vec_count, 3);
        reset = 1'b1; y_valid = 1'b1; y_data = rnd90();
        tick();
        reset = 1'b0; y_valid = 1'b0;
        chk("r_sig",   signature, SEED);
        chk("r_cnt",   vec_count, 0);
        chk("r_ready", y_ready, 0);
        chk("r_busy",  busy, 0);
        chk("r_done",  done, 0);
        tick();
        chk("r_idle_ready", y_ready, 0);
        model = SEED; acc = 0;
        do_start(16'd1);
        push(90'h0, model, acc);
        chk("r_fresh_sig", signature, 32'hFB3EE249);

        // back-to-back from DONE, two zero words: FB3EE249 -> F2BCD925
        for (int r = 0; r < 2; r++) begin
            model = SEED; acc = 0;
            do_start(16'd2);
            chk($sformatf("b%0d_done_drop", r), done, 0);
            chk($sformatf("b%0d_reseed", r), signature, SEED);
            push(90'h0, model, acc);
            chk($sformatf("b%0d_mid_done", r), done, 0);
            push(90'h0, model, acc);
            chk($sformatf("b%0d_sig", r), signature, 32'hF2BCD925);
            chk($sformatf("b%0d_done", r), done, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
